// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch / load-store) arbiter onto a single memory port
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_byte_en,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,

    output logic        mem_valid,
    output logic        mem_rw_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        stall_pc
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          grant_if;
    logic          grant_ls;

    // Load/store normally has priority; fetch wins once it has been passed over STARVE_LIMIT times
    assign starved  = (starve_cnt == CNT_MAX);
    assign grant_if = if_req & (~ls_req | starved);
    assign grant_ls = ls_req & ~grant_if;

    // Acks are combinational on mem_ready and are suppressed while reset is asserted
    assign if_ack   = (state == BUSY_IF) & mem_ready & ~i_rst;
    assign ls_ack   = (state == BUSY_LS) & mem_ready & ~i_rst;
    assign if_rdata = if_ack ? mem_rdata : 32'd0;
    assign ls_rdata = ls_ack ? mem_rdata : 32'd0;
    assign stall_pc = if_req & ~if_ack;

    // Transaction FSM: grant in IDLE, hold mem_* stable while busy, release on mem_ready
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            mem_valid      <= 1'b0;
            mem_rw_mode    <= 1'b0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_byte_en    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state          <= BUSY_IF;
                        mem_valid      <= 1'b1;
                        mem_rw_mode    <= 1'b0;
                        mem_addr       <= if_addr;
                        mem_write_data <= 32'd0;
                        mem_byte_en    <= 4'b1111;
                    end else if (grant_ls) begin
                        state          <= BUSY_LS;
                        mem_valid      <= 1'b1;
                        mem_rw_mode    <= ls_we;
                        mem_addr       <= ls_addr;
                        mem_write_data <= ls_we ? ls_wdata : 32'd0;
                        mem_byte_en    <= ls_byte_en;
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count load/store grants that bypass a waiting fetch; any fetch grant or idle fetch clears it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_if) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_ls && !starved) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive LS grants taken while IF waits, after which IF wins.
REQ-002 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; one clock, synchronous active-high reset.
REQ-004 SHALL have port if_req, input, 1, instruction fetch request, held until if_ack.
REQ-005 SHALL have port if_addr, input, 32, fetch address.
REQ-006 SHALL have port if_ack, output, 1, fetch complete pulse.
REQ-007 SHALL have port if_rdata, output, 32, fetch data, valid with if_ack.
REQ-008 SHALL have port ls_req, input, 1, load/store request, held until ls_ack.
REQ-009 SHALL have port ls_we, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port ls_addr, input, 32, load/store address.
REQ-011 SHALL have port ls_wdata, input, 32, store data.
REQ-012 SHALL have port ls_byte_en, input, 4, store/load byte lanes.
REQ-013 SHALL have port ls_ack, output, 1, load/store complete pulse.
REQ-014 SHALL have port ls_rdata, output, 32, load data, valid with ls_ack.
REQ-015 SHALL have port mem_valid, output, 1, transaction presented to memory.
REQ-016 SHALL have port mem_rw_mode, output, 1, 1 = write.
REQ-017 SHALL have port mem_addr, output, 32, memory address.
REQ-018 SHALL have port mem_write_data, output, 32, memory write data.
REQ-019 SHALL have port mem_byte_en, output, 4, memory byte enables.
REQ-020 SHALL have port mem_ready, input, 1, memory completion pulse.
REQ-021 SHALL have port mem_rdata, input, 32, read data, valid with mem_ready.
REQ-022 SHALL have port stall_pc, output, 1, fetch pending and not completing.

Function
REQ-023 SHALL use FSM states IDLE, BUSY_IF, BUSY_LS, with one outstanding memory transaction max.
REQ-024 SHALL, in IDLE with any request, pick a winner, register its fields into mem_* and enter BUSY_<winner> at the next edge.
REQ-025 SHALL arbitrate as follows: only one requester -> it wins; both requesting -> LS wins unless starve_cnt == STARVE_LIMIT, then IF wins.
REQ-026 SHALL drive IF transactions as mem_rw_mode=0, mem_byte_en=4'b1111, mem_write_data=0.
REQ-027 SHALL drive LS transactions as mem_rw_mode=ls_we, mem_byte_en=ls_byte_en; mem_write_data=ls_wdata if store, else 0.
REQ-028 SHALL hold mem_valid=1 in BUSY_* and 0 in IDLE; mem_* fields stay stable throughout BUSY_*.
REQ-029 SHALL assert if_ack (BUSY_IF) or ls_ack (BUSY_LS) combinationally in the cycle mem_ready=1, with *_rdata=mem_rdata, then return to IDLE.
REQ-030 SHALL drive if_rdata and ls_rdata to 0 when their ack is low.
REQ-031 SHALL ignore mem_ready while in IDLE: no ack, no state change.
REQ-032 SHALL give a minimum request-to-ack latency of 2 cycles (grant cycle + one BUSY cycle with mem_ready=1); back-to-back transactions have one IDLE cycle between them.
REQ-033 SHALL treat a req still high in the cycle after its ack as a new request.
REQ-034 SHALL keep starve_cnt, width clog2(STARVE_LIMIT+1), updated at each grant: LS grant with if_req=1 -> +1, saturating at STARVE_LIMIT; IF grant -> 0; cycle with if_req=0 -> 0.
REQ-035 SHALL assign stall_pc = if_req & ~if_ack.

Reset
REQ-036 SHALL, while i_rst=1 at the edge, go to IDLE with starve_cnt=0, mem_valid=0, mem_rw_mode=0, mem_addr=0, mem_write_data=0, mem_byte_en=0.
REQ-037 SHALL, on reset mid-transaction, abandon the transaction with no ack issued; a late mem_ready falls under REQ-031.
REQ-038 SHALL keep acks and rdata low during reset; stall_pc follows REQ-035.

Verification
REQ-039 SHALL cover: if_req=1 alone, if_addr=0x100, mem_ready one cycle after grant with rdata=0xDEADBEEF -> mem_addr=0x100, byte_en=F, if_ack with if_rdata=0xDEADBEEF at cycle 2, stall_pc low after.
REQ-040 SHALL cover: ls store addr=0x2004, wdata=0x55, byte_en=4'b0001 -> mem_rw_mode=1, mem_write_data=0x55, mem_byte_en=1, ls_ack on mem_ready.
REQ-041 SHALL cover: if_req and ls_req held high continuously, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS...
REQ-042 SHALL cover: mem_ready delayed 5 cycles -> mem_* stable 5 cycles, stall_pc high throughout for IF.
REQ-043 SHALL cover: i_rst pulsed in BUSY_LS, then mem_ready=1 -> no ls_ack, mem_valid=0, state IDLE.
REQ-044 SHALL cover: mem_ready=1 in IDLE with no request -> no ack, outputs unchanged.
